// File: rtl/four_way_burst_arbiter.sv
// Four-requester burst arbiter driving a downstream 4:1 mux select, VALID/READY toward the consumer.
// Build option SEL_FIXED_PRIO_EN: fixed priority (channel 0 highest) instead of round-robin.
module four_way_burst_arbiter #(
    parameter int BURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_ready,
    output logic [1:0] o_sel,
    output logic [3:0] o_gnt,
    output logic       o_valid,
    output logic       o_last
);

    localparam int            CW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);
    localparam logic          LAST_ON_GRANT = (BURST == 1);

    logic [1:0]    r_sel;
    logic [3:0]    r_gnt;
    logic          r_valid;
    logic          r_last;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_sel_n;
    logic [3:0]    w_gnt_n;
    logic          w_valid_n;
    logic          w_last_n;
    logic [CW-1:0] w_cnt_n;
    logic [1:0]    w_start;
    logic          w_acc;
    logic          w_hold;
    logic          w_win_vld;
    logic [1:0]    w_win;

    // First set request at or after 'start', wrapping 3->0; bit 2 flags a hit.
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef SEL_FIXED_PRIO_EN
    assign w_start = 2'd0;
`else
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_n;
    assign w_start = r_ptr;
`endif

    assign w_acc  = r_valid & i_ready;
    assign w_hold = r_valid & i_req[r_sel] & ~(w_acc & r_last);
    assign {w_win_vld, w_win} = pick(i_req, w_start);

    always_comb begin
        w_sel_n   = r_sel;
        w_gnt_n   = r_gnt;
        w_valid_n = r_valid;
        w_last_n  = r_last;
        w_cnt_n   = r_cnt;
`ifndef SEL_FIXED_PRIO_EN
        w_ptr_n   = r_ptr;
`endif
        if (w_hold) begin
            // Backpressure: everything frozen unless the beat was taken.
            if (w_acc) begin
                w_cnt_n  = r_cnt + 1'b1;
                w_last_n = (w_cnt_n == LAST_CNT);
            end
        end else if (w_win_vld) begin
            w_sel_n   = w_win;
            w_gnt_n   = 4'b0001 << w_win;
            w_valid_n = 1'b1;
            w_cnt_n   = '0;
            w_last_n  = LAST_ON_GRANT;
`ifndef SEL_FIXED_PRIO_EN
            w_ptr_n   = w_win + 2'd1;
`endif
        end else begin
            // Idle: SEL keeps its last value so the mux input does not toggle.
            w_valid_n = 1'b0;
            w_gnt_n   = 4'b0000;
            w_last_n  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sel   <= w_sel_n;
            r_gnt   <= w_gnt_n;
            r_valid <= w_valid_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
        end
    end

`ifndef SEL_FIXED_PRIO_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ptr <= 2'd0;
        else       r_ptr <= w_ptr_n;
    end
`endif

    assign o_sel   = r_sel;
    assign o_gnt   = r_gnt;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: tb/tb_four_way_burst_arbiter.sv
// Directed bench for four_way_burst_arbiter: one BURST=4 and one BURST=1 instance on shared stimulus.
module tb_four_way_burst_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel4, sel1;
    logic [3:0] gnt4, gnt1;
    logic       vld4, vld1;
    logic       last4, last1;

    int n_vec = 0;
    int n_err = 0;

    four_way_burst_arbiter #(.BURST(4)) u_b4 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_ready(ready),
        .o_sel(sel4), .o_gnt(gnt4), .o_valid(vld4), .o_last(last4)
    );

    four_way_burst_arbiter #(.BURST(1)) u_b1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_ready(ready),
        .o_sel(sel1), .o_gnt(gnt1), .o_valid(vld1), .o_last(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a granted beat on the BURST=4 instance.
    task automatic beat4(input string tag, input logic [1:0] s, input logic l);
        chk({tag, ".valid"}, 32'(vld4), 32'd1);
        chk({tag, ".sel"},   32'(sel4), 32'(s));
        chk({tag, ".gnt"},   32'(gnt4), 32'(4'b0001 << s));
        chk({tag, ".last"},  32'(last4), 32'(l));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_sel;

    initial begin
        rst = 1'b1; req = 4'b1111; ready = 1'b1;

        // Reset holds everything idle even with all requests active.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.valid", 32'(vld4), 32'd0);
            chk("rst.sel",   32'(sel4), 32'd0);
            chk("rst.gnt",   32'(gnt4), 32'd0);
            chk("rst.last",  32'(last4), 32'd0);
        end
        rst = 1'b0;
        tick();
        beat4("rst_first", 2'd0, 1'b0);

        // Lone requester: back-to-back regrant, LAST every 4th beat.
        do_reset();
        req = 4'b0001; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            beat4("lone", 2'd0, (i % 4) == 3);
        end

        // All four requesting: round-robin bursts of 4.
        do_reset();
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
`ifdef SEL_FIXED_PRIO_EN
            exp_sel = 2'd0;
`else
            exp_sel = 2'((i / 4) % 4);
`endif
            beat4("rr", exp_sel, (i % 4) == 3);
        end

        // Backpressure freeze on channel 2 after one accept.
        do_reset();
        req = 4'b0100; ready = 1'b1;
        tick();                      // beat 0 presented
        tick();                      // beat 0 accepted, beat 1 presented
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            beat4("bp_frz", 2'd2, 1'b0);
        end
        ready = 1'b1;
        tick(); beat4("bp_acc2", 2'd2, 1'b0);
        tick(); beat4("bp_acc3", 2'd2, 1'b1);
        req = 4'b0000;
        tick();                      // final beat accepted, nothing pending
        chk("idle.valid", 32'(vld4), 32'd0);
        chk("idle.gnt",   32'(gnt4), 32'd0);
        chk("idle.last",  32'(last4), 32'd0);
        chk("idle.sel",   32'(sel4), 32'd2);

        // Withdrawal mid-burst hands over to channel 2 with a fresh count.
        do_reset();
        req = 4'b0110; ready = 1'b1;
        tick(); beat4("wd_b0", 2'd1, 1'b0);
        tick(); beat4("wd_b1", 2'd1, 1'b0);
        tick(); beat4("wd_b2", 2'd1, 1'b0);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            beat4("wd_ch2", 2'd2, i == 3);
        end

        // Withdrawal under backpressure drops the presented beat uncounted.
        do_reset();
        req = 4'b0010; ready = 1'b1;
        tick();                      // beat 0 presented
        tick();                      // beat 0 accepted, beat 1 presented
        ready = 1'b0;
        tick(); beat4("wdbp_frz", 2'd1, 1'b0);
        req = 4'b0000;
        tick();
        chk("wdbp.valid", 32'(vld4), 32'd0);
        req = 4'b0010; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            beat4("wdbp_new", 2'd1, i == 3);
        end

        // BURST=1: every beat is LAST and rearbitrates.
        do_reset();
        req = 4'b1010; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef SEL_FIXED_PRIO_EN
            exp_sel = 2'd1;
`else
            exp_sel = (i % 2 == 0) ? 2'd1 : 2'd3;
`endif
            chk("b1.valid", 32'(vld1), 32'd1);
            chk("b1.last",  32'(last1), 32'd1);
            chk("b1.sel",   32'(sel1), 32'(exp_sel));
            chk("b1.gnt",   32'(gnt1), 32'(4'b0001 << exp_sel));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
